output_arbiter: RTL and testbench



---
 rtl/output_arbiter_pkg.sv | 23 ++
 rtl/output_arbiter_if.sv | 30 +++
 rtl/output_arbiter_rr_picker.sv | 29 ++
 rtl/output_arbiter.sv | 106 ++++++++++
 tb/tb_output_arbiter.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/output_arbiter_pkg.sv
// Shared router definitions: route codes, route-code width and input port indices.
// Used by the input controllers and by every output_arbiter instance.
package output_arbiter_pkg;

   localparam int unsigned N_REGISTER = 3;
   localparam int unsigned N_PORT     = 5;

   typedef enum logic [N_REGISTER-1:0] {
      LOCAL        = 3'b000,
      EAST         = 3'b001,
      WEST         = 3'b010,
      NORTH        = 3'b011,
      SOUTH        = 3'b100,
      NOT_REGISTER = 3'b111
   } route_t;

   localparam int unsigned PORT_L = 0;
   localparam int unsigned PORT_E = 1;
   localparam int unsigned PORT_W = 2;
   localparam int unsigned PORT_N = 3;
   localparam int unsigned PORT_S = 4;

endpackage

// File: rtl/output_arbiter_if.sv
// Request/grant/output-link bundle between the input controllers and one output arbiter.
// The master side drives requests and flow control; the slave side is the arbiter.
interface output_arbiter_if
   import output_arbiter_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned N_REGISTER = output_arbiter_pkg::N_REGISTER,
   parameter int unsigned N_PORT     = output_arbiter_pkg::N_PORT
);

   logic [N_PORT*N_REGISTER-1:0] req_register;
   logic [N_PORT*DATA_WIDTH-1:0] req_data;
   logic [N_PORT-1:0]            grant;
   logic [DATA_WIDTH-1:0]        data_out;
   logic                         valid_out;
   logic                         full_in;
   logic                         credit_in;
   logic                         credit_err;

   modport master (
      output req_register, req_data, full_in, credit_in,
      input  grant, data_out, valid_out, credit_err
   );

   modport slave (
      input  req_register, req_data, full_in, credit_in,
      output grant, data_out, valid_out, credit_err
   );

endinterface

// File: rtl/output_arbiter_rr_picker.sv
// Combinational round-robin picker: first eligible index after i_ptr wins.
// Produces a one-hot winner and an any-winner flag.
module rr_picker #(
   parameter int unsigned N_PORT = 5
) (
   input  logic [N_PORT-1:0]         i_eligible,
   input  logic [$clog2(N_PORT)-1:0] i_ptr,
   output logic [N_PORT-1:0]         o_grant,
   output logic                      o_any
);

   localparam int unsigned IW = $clog2(N_PORT);

   logic [IW-1:0] w_idx;

   always_comb begin
      o_grant = '0;
      o_any   = 1'b0;
      w_idx   = '0;
      for (int unsigned off = 1; off <= N_PORT; off++) begin
         w_idx = IW'((32'(i_ptr) + off) % N_PORT);
         if (!o_any && i_eligible[w_idx]) begin
            o_grant[w_idx] = 1'b1;
            o_any          = 1'b1;
         end
      end
   end

endmodule

// File: rtl/output_arbiter.sv
// Per-output-port switch allocator: round-robin grant, registered flit output, flow control.
// Build with OUTPUT_ARB_CREDIT_EN for credit-based flow control; otherwise full_in gates grants.
module output_arbiter
   import output_arbiter_pkg::*;
#(
   parameter int unsigned             DATA_WIDTH = 8,
   parameter int unsigned             N_REGISTER = output_arbiter_pkg::N_REGISTER,
   parameter int unsigned             N_PORT     = output_arbiter_pkg::N_PORT,
   parameter logic [N_REGISTER-1:0]   PORT_ID    = LOCAL,
   parameter int unsigned             CREDITS    = 4
) (
   input  logic             clk,
   input  logic             rst,
   output_arbiter_if.slave  bus
);

   localparam int unsigned PW = $clog2(N_PORT);

   logic [N_PORT-1:0]     r_grant;
   logic [PW-1:0]         r_ptr;
   logic [DATA_WIDTH-1:0] r_data;
   logic                  r_valid;

   logic [N_PORT-1:0]     w_eligible;
   logic [N_PORT-1:0]     w_win;
   logic                  w_any;
   logic                  w_allow;
   logic [PW-1:0]         w_win_idx;
   logic [DATA_WIDTH-1:0] w_sel_data;
   logic                  w_unused;

   // The currently granted port doubles as the mask: its route code is stale while it pops.
   always_comb begin
      w_eligible = '0;
      for (int unsigned i = 0; i < N_PORT; i++) begin
         w_eligible[i] = w_allow && !r_grant[i] &&
                         (bus.req_register[i*N_REGISTER +: N_REGISTER] == PORT_ID);
      end
   end

   rr_picker #(
      .N_PORT (N_PORT)
   ) u_picker (
      .i_eligible (w_eligible),
      .i_ptr      (r_ptr),
      .o_grant    (w_win),
      .o_any      (w_any)
   );

   always_comb begin
      w_win_idx  = '0;
      w_sel_data = '0;
      for (int unsigned i = 0; i < N_PORT; i++) begin
         if (w_win[i]) w_win_idx = PW'(i);
         if (r_grant[i]) w_sel_data |= bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_grant <= '0;
         r_ptr   <= PW'(N_PORT - 1);
         r_data  <= '0;
         r_valid <= 1'b0;
      end else begin
         r_grant <= w_win;
         if (w_any) r_ptr <= w_win_idx;
         r_valid <= |r_grant;
         if (|r_grant) r_data <= w_sel_data;
      end
   end

`ifdef OUTPUT_ARB_CREDIT_EN
   localparam int unsigned CW = $clog2(CREDITS + 1);

   logic [CW-1:0] r_credit;
   logic          r_credit_err;

   assign w_allow = (r_credit != '0);

   // A grant and a credit return in the same cycle cancel out.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_credit     <= CW'(CREDITS);
         r_credit_err <= 1'b0;
      end else if (w_any && !bus.credit_in) begin
         r_credit <= r_credit - 1'b1;
      end else if (!w_any && bus.credit_in) begin
         if (r_credit == CW'(CREDITS)) r_credit_err <= 1'b1;
         else                          r_credit     <= r_credit + 1'b1;
      end
   end

   assign bus.credit_err = r_credit_err;
   assign w_unused       = bus.full_in;
`else
   assign w_allow        = !bus.full_in;
   assign bus.credit_err = 1'b0;
   assign w_unused       = bus.credit_in;
`endif

   assign bus.grant     = r_grant;
   assign bus.data_out  = r_data;
   assign bus.valid_out = r_valid;

endmodule

// File: tb/tb_output_arbiter.sv
// Directed bench for output_arbiter with a grant/flit scoreboard checked on the falling edge.
// Covers OUTPUT_ARB_CREDIT_EN when the macro is defined for the build.
module tb_output_arbiter;
   import output_arbiter_pkg::*;

   localparam int unsigned DW = 8;
   localparam int unsigned NR = 3;
   localparam int unsigned NP = 5;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   output_arbiter_if #(.DATA_WIDTH(DW), .N_REGISTER(NR), .N_PORT(NP)) bus ();

   output_arbiter #(
      .DATA_WIDTH (DW),
      .N_REGISTER (NR),
      .N_PORT     (NP),
      .PORT_ID    (LOCAL),
      .CREDITS    (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int errors = 0;
   int checks = 0;

   logic [NP-1:0] exp_grant_q[$];
   logic [DW-1:0] exp_data_q[$];
   logic [NP-1:0] mon_g;
   logic [DW-1:0] mon_d;

   task automatic step(input int unsigned n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic set_req(input int unsigned p, input logic [NR-1:0] code, input logic [DW-1:0] d);
      bus.req_register[p*NR +: NR] = code;
      bus.req_data[p*DW +: DW]     = d;
   endtask

   task automatic idle_all();
      for (int unsigned p = 0; p < NP; p++) bus.req_register[p*NR +: NR] = NOT_REGISTER;
   endtask

   task automatic expect_flit(input int unsigned p, input logic [DW-1:0] d);
      exp_grant_q.push_back(NP'(1) << p);
      exp_data_q.push_back(d);
   endtask

   // Scoreboard: every grant and every valid flit must match the next queued expectation.
   always @(negedge clk) begin
      if (!$isunknown(bus.grant) && bus.grant != '0) begin
         checks++;
         assert (exp_grant_q.size() != 0) else begin
            errors++;
            $error("FAIL sb_grant_unexpected got=%b exp=none", bus.grant);
         end
         if (exp_grant_q.size() != 0) begin
            mon_g = exp_grant_q.pop_front();
            checks++;
            assert (bus.grant === mon_g) else begin
               errors++;
               $error("FAIL sb_grant got=%b exp=%b", bus.grant, mon_g);
            end
         end
      end
      if (bus.valid_out === 1'b1) begin
         checks++;
         assert (exp_data_q.size() != 0) else begin
            errors++;
            $error("FAIL sb_data_unexpected got=%h exp=none", bus.data_out);
         end
         if (exp_data_q.size() != 0) begin
            mon_d = exp_data_q.pop_front();
            checks++;
            assert (bus.data_out === mon_d) else begin
               errors++;
               $error("FAIL sb_data got=%h exp=%h", bus.data_out, mon_d);
            end
         end
      end
   end

   initial begin
      rst           = 1'b1;
      bus.full_in   = 1'b0;
      bus.credit_in = 1'b0;
      bus.req_data  = '0;
      idle_all();

      // Reset
      step(2);
      chk("rst_grant", 32'(bus.grant), 0);
      chk("rst_valid", 32'(bus.valid_out), 0);
      chk("rst_data", 32'(bus.data_out), 0);
      chk("rst_credit_err", 32'(bus.credit_err), 0);
      rst = 1'b0;

      // Single request from E
      set_req(PORT_E, LOCAL, 8'hA5);
      expect_flit(PORT_E, 8'hA5);
      step();
      chk("single_grant", 32'(bus.grant), 32'b00010);
      chk("single_valid_early", 32'(bus.valid_out), 0);
      idle_all();
      step();
      chk("single_valid", 32'(bus.valid_out), 1);
      chk("single_data", 32'(bus.data_out), 32'hA5);
      chk("single_grant_drop", 32'(bus.grant), 0);
      step();
      chk("single_valid_pulse", 32'(bus.valid_out), 0);
      chk("single_data_hold", 32'(bus.data_out), 32'hA5);

      // Full contention from reset pointer
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int unsigned p = 0; p < NP; p++) set_req(p, LOCAL, DW'(8'h10 + p));
      for (int unsigned k = 0; k < 6; k++) expect_flit(k % NP, DW'(8'h10 + (k % NP)));
      for (int unsigned k = 0; k < 6; k++) begin
         step();
         chk("rr_grant", 32'(bus.grant), 32'(1) << (k % NP));
         if (k > 0) begin
            chk("rr_valid", 32'(bus.valid_out), 1);
            chk("rr_data", 32'(bus.data_out), 32'h10 + ((k - 1) % NP));
         end
      end
      idle_all();
      step();
      chk("rr_last_data", 32'(bus.data_out), 32'h10);
      chk("rr_idle_grant", 32'(bus.grant), 0);
      step();
      chk("rr_idle_valid", 32'(bus.valid_out), 0);

      // Route-code mismatch and idle code
      set_req(0, EAST, 8'h01);
      set_req(1, NOT_REGISTER, 8'h02);
      set_req(2, EAST, 8'h03);
      set_req(3, NORTH, 8'h04);
      set_req(4, SOUTH, 8'h05);
      for (int unsigned k = 0; k < 3; k++) begin
         step();
         chk("mismatch_grant", 32'(bus.grant), 0);
         chk("mismatch_valid", 32'(bus.valid_out), 0);
      end
      idle_all();

`ifdef OUTPUT_ARB_CREDIT_EN
      rst = 1'b1;
      step();
      rst = 1'b0;
      bus.full_in = 1'b1;
      for (int unsigned p = 0; p < NP; p++) set_req(p, LOCAL, DW'(8'h20 + p));
      for (int unsigned k = 0; k < 4; k++) expect_flit(k, DW'(8'h20 + k));
      for (int unsigned k = 0; k < 4; k++) begin
         step();
         chk("cr_grant", 32'(bus.grant), 32'(1) << k);
      end
      step();
      chk("cr_stall_grant", 32'(bus.grant), 0);
      chk("cr_stall_data", 32'(bus.data_out), 32'h23);
      step();
      chk("cr_stall_grant2", 32'(bus.grant), 0);
      bus.credit_in = 1'b1;
      expect_flit(PORT_S, 8'h24);
      step();
      bus.credit_in = 1'b0;
      chk("cr_ret_wait", 32'(bus.grant), 0);
      step();
      chk("cr_ret_grant", 32'(bus.grant), 32'b10000);
      idle_all();
      step();
      chk("cr_ret_data", 32'(bus.data_out), 32'h24);
      chk("cr_err_clear", 32'(bus.credit_err), 0);
      bus.credit_in = 1'b1;
      step(4);
      chk("cr_err_at_full", 32'(bus.credit_err), 0);
      step();
      bus.credit_in = 1'b0;
      chk("cr_err_set", 32'(bus.credit_err), 1);
      step();
      chk("cr_err_sticky", 32'(bus.credit_err), 1);
      bus.full_in = 1'b0;
`else
      bus.full_in = 1'b1;
      set_req(PORT_N, LOCAL, 8'h3C);
      for (int unsigned k = 0; k < 3; k++) begin
         step();
         chk("full_block", 32'(bus.grant), 0);
      end
      bus.full_in = 1'b0;
      expect_flit(PORT_N, 8'h3C);
      step();
      chk("full_release", 32'(bus.grant), 32'b01000);
      idle_all();
      step();
      chk("full_valid", 32'(bus.valid_out), 1);
      chk("full_data", 32'(bus.data_out), 32'h3C);
      bus.credit_in = 1'b1;
      step();
      bus.credit_in = 1'b0;
      chk("no_credit_err", 32'(bus.credit_err), 0);
`endif

      // Reset during a grant cycle discards the in-flight flit
      step();
      set_req(PORT_W, LOCAL, 8'h77);
      exp_grant_q.push_back(5'b00100);
      step();
      chk("rstmid_grant", 32'(bus.grant), 32'b00100);
      rst = 1'b1;
      idle_all();
      step();
      chk("rstmid_valid", 32'(bus.valid_out), 0);
      chk("rstmid_grant_clr", 32'(bus.grant), 0);
      chk("rstmid_data", 32'(bus.data_out), 0);
      rst = 1'b0;
      step();
      chk("rstmid_valid_after", 32'(bus.valid_out), 0);

      step(2);
      chk("sb_grant_drained", 32'(exp_grant_q.size()), 0);
      chk("sb_data_drained", 32'(exp_data_q.size()), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
